// File: rtl/palindrome_stream_gen_if.sv
// Purpose : bundles the seed handshake, the serial stream and the parallel
//           word result of palindrome_stream_gen into one interface.
// Signals : seed/in_valid/in_ready  - seed handshake (source -> generator)
//           ser_data/ser_valid/ser_ready/ser_last - serial stream, MSB first
//           pal_word                - last built palindrome word
//           done                    - one-cycle pulse after the final bit
// Modports: master - seed source / serial sink side
//           slave  - generator side
interface palindrome_stream_gen_if #(
   parameter int unsigned HALF_W = 4,
   parameter int unsigned ODD    = 0
);
   localparam int unsigned PAL_W = (ODD != 0) ? 2 * HALF_W - 1 : 2 * HALF_W;

   logic [HALF_W-1:0] seed;
   logic              in_valid;
   logic              in_ready;
   logic              ser_data;
   logic              ser_valid;
   logic              ser_ready;
   logic              ser_last;
   logic [PAL_W-1:0]  pal_word;
   logic              done;

   modport master (
      output seed, in_valid, ser_ready,
      input  in_ready, ser_data, ser_valid, ser_last, pal_word, done
   );

   modport slave (
      input  seed, in_valid, ser_ready,
      output in_ready, ser_data, ser_valid, ser_last, pal_word, done
   );
endinterface

// File: rtl/palindrome_stream_gen.sv
// Purpose : accepts a half-word seed, builds the mirrored palindrome word
//           (even: {seed, rev(seed)}; odd: centre bit not duplicated),
//           shifts it out MSB first under valid/ready backpressure and holds
//           the full word on pal_word until the next seed is accepted.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - palindrome_stream_gen_if.slave (seed handshake, serial
//                   stream, pal_word, done)
module palindrome_stream_gen #(
   parameter int unsigned HALF_W = 4,
   parameter int unsigned ODD    = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   palindrome_stream_gen_if.slave        bus
);
   localparam int unsigned PAL_W = (ODD != 0) ? 2 * HALF_W - 1 : 2 * HALF_W;
   localparam int unsigned CW    = $clog2(PAL_W);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t            r_state;
   logic [PAL_W-1:0]  r_shift;
   logic [PAL_W-1:0]  r_pal;
   logic [CW-1:0]     r_cnt;
   logic              r_in_ready;
   logic              r_ser_valid;
   logic              r_ser_last;
   logic              r_done;

   logic [HALF_W-1:0] w_rev;
   logic [PAL_W-1:0]  w_word;

   always_comb begin
      w_rev = '0;
      for (int unsigned i = 0; i < HALF_W; i++) begin
         w_rev[i] = bus.seed[HALF_W-1-i];
      end
   end

   // For the odd form, rev(seed[HALF_W-1:1]) is exactly the low HALF_W-1
   // bits of rev(seed), so the centre bit (seed[0]) appears only once.
   generate
      if (ODD != 0) begin : g_odd
         assign w_word = {bus.seed, w_rev[HALF_W-2:0]};
      end else begin : g_even
         assign w_word = {bus.seed, w_rev};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_pal       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_ser_valid <= 1'b0;
         r_ser_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_pal       <= w_word;
                  r_shift     <= w_word;
                  r_cnt       <= CW'(PAL_W - 1);
                  r_in_ready  <= 1'b0;
                  r_ser_valid <= 1'b1;
                  r_ser_last  <= 1'b0;
                  r_state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.ser_ready) begin
                  // Shifting on the final handshake too leaves the register
                  // all-zero, so ser_data idles low between words.
                  r_shift <= {r_shift[PAL_W-2:0], 1'b0};
                  if (r_cnt == '0) begin
                     r_state     <= S_IDLE;
                     r_in_ready  <= 1'b1;
                     r_ser_valid <= 1'b0;
                     r_ser_last  <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_cnt      <= r_cnt - 1'b1;
                     // ser_last is registered: it rises with the bit whose
                     // counter value will be zero.
                     r_ser_last <= (r_cnt == CW'(1));
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.ser_data  = r_shift[PAL_W-1];
   assign bus.ser_valid = r_ser_valid;
   assign bus.ser_last  = r_ser_last;
   assign bus.pal_word  = r_pal;
   assign bus.done      = r_done;
endmodule

// File: doc/palindrome_stream_gen.md
Name: palindrome_stream_gen

Overview:
- Generator counterpart to the team's combinational palindrome checker.
- Accepts a half-word seed over a valid/ready handshake and builds the mirrored palindrome word.
- Shifts the word out serially, MSB first, with per-bit valid/ready backpressure, and holds the full word on a parallel output so a downstream checker can confirm it.
- Sits between a seed source (register block or test pattern engine) and a serial link or checker.

Parameters:
- HALF_W, 4, seed width in bits; legal range 2..16.
- ODD, 0, 0 = even palindrome of width PAL_W = 2*HALF_W; 1 = odd palindrome of width PAL_W = 2*HALF_W-1, with the centre bit not duplicated.
- PAL_W (localparam) = ODD ? 2*HALF_W-1 : 2*HALF_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed  input  HALF_W  half-word to be mirrored; it forms the upper half of the palindrome.
- in_valid  input  1  seed is valid.
- in_ready  output  1  block can accept a seed; high only in IDLE.
- ser_data  output  1  current serial bit (MSB of the remaining word).
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  sink accepts ser_data this cycle.
- ser_last  output  1  ser_data is the final bit of the word; qualified by ser_valid.
- pal_word  output  PAL_W  most recently built palindrome; held until the next seed is accepted.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - ser_valid=0, ser_last=0, done=0, ser_data=0.
  - pal_word=0, shift register=0, bit counter=0.
  - in_ready=1 once reset is released.
  - Reset during SHIFT abandons the word; no partial done is generated.
- Word construction, at the accept cycle:
  - Even (ODD=0): word = {seed, bit-reverse(seed)}.
  - Odd (ODD=1): word = {seed, bit-reverse(seed[HALF_W-1:1])}.
  - pal_word and the shift register load together. The bit counter loads PAL_W-1.
- States:
  - IDLE:
    - in_ready=1, ser_valid=0.
    - On in_valid && in_ready: load as above and go to SHIFT.
    - in_valid low keeps the block in IDLE.
  - SHIFT:
    - in_ready=0, ser_valid=1, ser_data = shift_reg[PAL_W-1], ser_last = (counter==0).
    - On ser_valid && ser_ready with counter != 0: shift left by one (zero fill) and decrement the counter.
    - On ser_valid && ser_ready with counter == 0: go to IDLE and assert done for exactly the next cycle.
    - With ser_ready low, ser_data, ser_last and the counter hold unchanged, with no limit on stall length.
- Timing:
  - Seed accepted at edge T: ser_valid=1 after edge T, and the first bit is presented in cycle T+1.
  - pal_word is updated after edge T as well.
  - With ser_ready held high, bit k is presented in cycle T+1+k, and ser_last is presented in cycle T+PAL_W.
  - done is high in the cycle after the last handshake, which is also the first cycle in_ready is high again.
  - Minimum period is PAL_W+1 cycles per word.
- Boundary conditions:
  - in_valid asserted during SHIFT is ignored, and the seed is not sampled.
  - A seed presented in the same cycle done is high is accepted normally (back-to-back operation).
  - ser_ready high while ser_valid is low has no effect.
  - All registers are clocked by clk only; there is no combinational path from seed to ser_data.
  - pal_word must always satisfy the team's palindrome checker: the word equals its own bit reversal.

Test Plan:
- HALF_W=4, ODD=0, seed=4'b1011, ser_ready tied 1 -> pal_word=8'b10111101; ser_data sequence 1,0,1,1,1,1,0,1 in cycles T+1..T+8; ser_last only on the 8th bit; done high at T+9; palindrome checker on pal_word reports 1.
- Same seed, ser_ready low for 3 cycles at bit index 2 -> ser_data holds 1 with ser_valid high through the stall; the total sequence is unchanged; done is delayed 3 cycles.
- HALF_W=4, ODD=1, seed=4'b1011 -> pal_word=7'b1011101; 7 bits shifted; ser_last on the 7th bit.
- in_valid held high throughout with seeds 4'hA then 4'h3 -> 4'hA is accepted first and words 8'b10100101 and 8'b00111100 are emitted back to back; the second seed is accepted in the done cycle; no seed is sampled during SHIFT.
- rst_n pulsed low during bit 4 of seed 4'hF -> outputs clear immediately (ser_valid=0, pal_word=0); no done pulse; after release, seed 4'h1 produces 8'b00011000 correctly.
- Sweep all 16 seeds for HALF_W=4, ODD=0 -> every pal_word passes the palindrome checker; the serial stream matches pal_word MSB first.
